// File: rtl/core_pkg.sv
// Shared core types: queue sizing and the store data queue entry record.
package core_pkg;

   localparam int unsigned SDQ_ENTRIES = 16;
   localparam int unsigned ROB_ENTRIES = 16;
   localparam int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES);

   typedef struct packed {
      logic                 valid;
      logic                 addr_valid;
      logic                 committed;
      logic                 issued;
      logic [ROB_IDX_W-1:0] rob_entry_idx;
      logic [31:0]          addr;
      logic [31:0]          data;
   } sdq_entry_t;

endpackage

// File: rtl/store_data_queue.sv
// Store data queue: in-order allocation, out-of-order address/data fill,
// in-order commit and a two-state drain engine feeding the D-cache.
module store_data_queue #(
   parameter int unsigned SDQ_ENTRIES = core_pkg::SDQ_ENTRIES,
   parameter int unsigned ROB_ENTRIES = core_pkg::ROB_ENTRIES
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           alloc_valid,
   input  logic [$clog2(ROB_ENTRIES)-1:0] alloc_rob_idx,
   output logic                           alloc_ready,
   output logic [$clog2(SDQ_ENTRIES)-1:0] alloc_sdq_idx,
   output logic [$clog2(SDQ_ENTRIES):0]   alloc_sdq_marker,
   input  logic                           exec_valid,
   input  logic [$clog2(SDQ_ENTRIES)-1:0] exec_sdq_idx,
   input  logic [31:0]                    exec_addr,
   input  logic [31:0]                    exec_data,
   input  logic                           commit_valid,
   input  logic [$clog2(ROB_ENTRIES)-1:0] commit_rob_idx,
   input  logic                           flush,
   output logic                           mem_req_valid,
   output logic [31:0]                    mem_req_addr,
   output logic [31:0]                    mem_req_data,
   input  logic                           mem_req_ready,
   input  logic                           mem_ack,
   output logic                           empty,
   output logic                           full,
   output logic [$clog2(SDQ_ENTRIES):0]   count
);

   import core_pkg::sdq_entry_t;

   localparam int unsigned IW = $clog2(SDQ_ENTRIES);
   localparam int unsigned PW = IW + 1;

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } drain_state_t;

   drain_state_t  state;
   sdq_entry_t    entries [SDQ_ENTRIES];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] commit_ptr;
   logic [PW-1:0] tail_ptr;
   logic [PW-1:0] commit_next;
   logic [IW-1:0] head_idx;
   logic [IW-1:0] commit_idx;
   logic [IW-1:0] tail_idx;
   logic          alloc_fire;
   logic          commit_fire;
   logic          issue_fire;
   sdq_entry_t    head_entry;

   always_comb begin
      head_idx    = head_ptr[IW-1:0];
      commit_idx  = commit_ptr[IW-1:0];
      tail_idx    = tail_ptr[IW-1:0];
      head_entry  = entries[head_idx];
      count       = tail_ptr - head_ptr;
      full        = (count == PW'(SDQ_ENTRIES));
      empty       = (count == '0);
      alloc_ready = !full && !flush;
      alloc_fire  = alloc_valid && alloc_ready;
      commit_fire = commit_valid && (commit_ptr != tail_ptr);
      commit_next = commit_ptr + PW'(commit_fire);
      // Request depends only on registered state; the issued bit keeps a
      // store from being offered twice.
      mem_req_valid = (state == IDLE) && head_entry.valid && head_entry.committed &&
                      head_entry.addr_valid && !head_entry.issued;
      mem_req_addr  = mem_req_valid ? head_entry.addr : '0;
      mem_req_data  = mem_req_valid ? head_entry.data : '0;
      issue_fire    = mem_req_valid && mem_req_ready;
      alloc_sdq_idx    = tail_idx;
      alloc_sdq_marker = tail_ptr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SDQ_ENTRIES; i++) begin
            entries[i] <= '0;
         end
         head_ptr   <= '0;
         commit_ptr <= '0;
         tail_ptr   <= '0;
         state      <= IDLE;
      end else begin
         if (exec_valid && entries[exec_sdq_idx].valid) begin
            entries[exec_sdq_idx].addr       <= exec_addr;
            entries[exec_sdq_idx].data       <= exec_data;
            entries[exec_sdq_idx].addr_valid <= 1'b1;
         end

         if (alloc_fire) begin
            entries[tail_idx].valid         <= 1'b1;
            entries[tail_idx].addr_valid    <= 1'b0;
            entries[tail_idx].committed     <= 1'b0;
            entries[tail_idx].issued        <= 1'b0;
            entries[tail_idx].rob_entry_idx <= alloc_rob_idx;
            tail_ptr                        <= tail_ptr + 1'b1;
         end

         if (commit_fire) begin
            entries[commit_idx].committed <= 1'b1;
            commit_ptr                    <= commit_next;
         end

         case (state)
            IDLE: begin
               if (issue_fire) begin
                  entries[head_idx].issued <= 1'b1;
                  state                    <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (mem_ack) begin
                  entries[head_idx].valid <= 1'b0;
                  head_ptr                <= head_ptr + 1'b1;
                  state                   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Squash everything younger than the post-commit pointer; committed
         // entries (including the one in flight) are untouched.
         if (flush) begin
            tail_ptr <= commit_next;
            for (int unsigned i = 0; i < SDQ_ENTRIES; i++) begin
               if (entries[i].valid && !entries[i].committed &&
                   !(commit_fire && (commit_idx == IW'(i)))) begin
                  entries[i].valid <= 1'b0;
               end
            end
         end
      end
   end

   commit_has_entry: assert property (@(posedge clk) disable iff (!rst_n)
      commit_valid |-> (commit_ptr != tail_ptr));

   commit_tag_match: assert property (@(posedge clk) disable iff (!rst_n)
      commit_fire |-> (entries[commit_idx].rob_entry_idx == commit_rob_idx));

endmodule

// File: tb/tb_store_data_queue.sv
// Self-checking bench for store_data_queue: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_store_data_queue;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alloc_valid = 1'b0;
   logic [3:0]  alloc_rob_idx = '0;
   logic        alloc_ready;
   logic [3:0]  alloc_sdq_idx;
   logic [4:0]  alloc_sdq_marker;
   logic        exec_valid = 1'b0;
   logic [3:0]  exec_sdq_idx = '0;
   logic [31:0] exec_addr = '0;
   logic [31:0] exec_data = '0;
   logic        commit_valid = 1'b0;
   logic [3:0]  commit_rob_idx = '0;
   logic        flush = 1'b0;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_data;
   logic        mem_req_ready = 1'b0;
   logic        mem_ack = 1'b0;
   logic        empty;
   logic        full;
   logic [4:0]  count;

   int errors = 0;
   int checks = 0;

   // Reference model: unbounded sequence numbers, slot = seq mod N.
   int          m_head, m_commit, m_tail;
   bit          m_wait;
   bit          m_valid [N];
   bit          m_av    [N];
   bit          m_cm    [N];
   logic [3:0]  m_rob   [N];
   logic [31:0] m_addr  [N];
   logic [31:0] m_data  [N];

   store_data_queue #(.SDQ_ENTRIES(16), .ROB_ENTRIES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_rob_idx(alloc_rob_idx),
      .alloc_ready(alloc_ready), .alloc_sdq_idx(alloc_sdq_idx),
      .alloc_sdq_marker(alloc_sdq_marker),
      .exec_valid(exec_valid), .exec_sdq_idx(exec_sdq_idx),
      .exec_addr(exec_addr), .exec_data(exec_data),
      .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
      .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
      .mem_ack(mem_ack),
      .empty(empty), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_req();
      int h = m_head % N;
      return !m_wait && m_valid[h] && m_cm[h] && m_av[h];
   endfunction

   task automatic m_reset();
      m_head = 0; m_commit = 0; m_tail = 0; m_wait = 0;
      for (int k = 0; k < N; k++) begin
         m_valid[k] = 0; m_av[k] = 0; m_cm[k] = 0;
         m_rob[k] = '0; m_addr[k] = '0; m_data[k] = '0;
      end
   endtask

   task automatic compare_all();
      bit req = m_req();
      int cnt = m_tail - m_head;
      check("count", 32'(count), 32'(cnt));
      check("empty", 32'(empty), 32'(cnt == 0));
      check("full", 32'(full), 32'(cnt == N));
      check("alloc_ready", 32'(alloc_ready), 32'((cnt != N) && !flush));
      check("alloc_sdq_idx", 32'(alloc_sdq_idx), 32'(m_tail % N));
      check("alloc_sdq_marker", 32'(alloc_sdq_marker), 32'(m_tail % (2 * N)));
      check("mem_req_valid", 32'(mem_req_valid), 32'(req));
      check("mem_req_addr", mem_req_addr, req ? m_addr[m_head % N] : 32'h0);
      check("mem_req_data", mem_req_data, req ? m_data[m_head % N] : 32'h0);
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic tick(input bit a, input logic [3:0] rob, input bit e, input logic [3:0] ei,
                       input logic [31:0] ea, input logic [31:0] ed, input bit c, input bit f,
                       input bit rdy, input bit ack);
      bit pre_req  = m_req();
      bit pre_full = (m_tail - m_head) == N;
      bit c_ok     = c && (m_commit < m_tail);
      alloc_valid = a; alloc_rob_idx = rob;
      exec_valid = e; exec_sdq_idx = ei; exec_addr = ea; exec_data = ed;
      commit_valid = c_ok; commit_rob_idx = m_rob[m_commit % N];
      flush = f; mem_req_ready = rdy; mem_ack = ack;

      if (e && m_valid[ei]) begin
         m_addr[ei] = ea; m_data[ei] = ed; m_av[ei] = 1;
      end
      if (c_ok) begin
         m_cm[m_commit % N] = 1;
         m_commit++;
      end
      if (a && !pre_full && !f) begin
         m_valid[m_tail % N] = 1; m_av[m_tail % N] = 0;
         m_cm[m_tail % N] = 0; m_rob[m_tail % N] = rob;
         m_tail++;
      end
      if (m_wait && ack) begin
         m_valid[m_head % N] = 0;
         m_head++;
         m_wait = 0;
      end else if (pre_req && rdy) begin
         m_wait = 1;
      end
      if (f) begin
         for (int k = m_commit; k < m_tail; k++) m_valid[k % N] = 0;
         m_tail = m_commit;
      end

      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle_tick();
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      alloc_valid = 0; exec_valid = 0; commit_valid = 0; flush = 0;
      mem_req_ready = 0; mem_ack = 0;
      rst_n = 0;
      #2;
      m_reset();
      check("rst_empty", 32'(empty), 32'h1);
      check("rst_full", 32'(full), 32'h0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_alloc_ready", 32'(alloc_ready), 32'h1);
      check("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
      check("rst_mem_req_addr", mem_req_addr, 32'h0);
      check("rst_mem_req_data", mem_req_data, 32'h0);
      check("rst_marker", 32'(alloc_sdq_marker), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      m_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Single store end to end.
      tick(1, 4'd3, 0, '0, '0, '0, 0, 0, 0, 0);
      tick(0, '0, 1, 4'd0, 32'h100, 32'hAA, 0, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 1, 0, 0, 0);
      check("e2e_req_valid", 32'(mem_req_valid), 32'h1);
      check("e2e_req_addr", mem_req_addr, 32'h100);
      check("e2e_req_data", mem_req_data, 32'hAA);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      check("e2e_wait_req_low", 32'(mem_req_valid), 32'h0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("e2e_empty", 32'(empty), 32'h1);

      // Back-pressure: request holds, early acks are ignored.
      tick(1, 4'd7, 0, '0, '0, '0, 0, 0, 0, 0);
      tick(0, '0, 1, 4'd1, 32'h200, 32'h55, 1, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 1, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
         check("stall_req_valid", 32'(mem_req_valid), 32'h1);
         check("stall_req_addr", mem_req_addr, 32'h200);
         check("stall_req_data", mem_req_data, 32'h55);
      end
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("stall_empty", 32'(empty), 32'h1);

      // Fill to full, then drain one and see the wrapped marker.
      do_reset();
      for (int k = 0; k < N + 1; k++) tick(1, 4'(k), 0, '0, '0, '0, 0, 0, 0, 0);
      check("fill_full", 32'(full), 32'h1);
      check("fill_alloc_ready", 32'(alloc_ready), 32'h0);
      tick(0, '0, 1, 4'd0, 32'h300, 32'h1, 1, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("wrap_alloc_ready", 32'(alloc_ready), 32'h1);
      check("wrap_marker", 32'(alloc_sdq_marker), 32'h10);

      // Flush keeps committed stores, which then drain in order.
      do_reset();
      for (int k = 0; k < 4; k++) tick(1, 4'(k + 8), 0, '0, '0, '0, 0, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 1, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 1, 1, 0, 0);
      check("flush_count", 32'(count), 32'h2);
      check("flush_marker", 32'(alloc_sdq_marker), 32'h2);
      tick(0, '0, 1, 4'd1, 32'h410, 32'hB1, 0, 0, 0, 0);
      tick(0, '0, 1, 4'd0, 32'h400, 32'hB0, 0, 0, 0, 0);
      check("flush_drain0_addr", mem_req_addr, 32'h400);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("flush_drain1_addr", mem_req_addr, 32'h410);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("flush_drained", 32'(empty), 32'h1);

      // Flush with a same-cycle alloc: the alloc is dropped.
      do_reset();
      for (int k = 0; k < 3; k++) tick(1, 4'(k), 0, '0, '0, '0, 0, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 1, 0, 0, 0);
      tick(1, 4'd9, 0, '0, '0, '0, 0, 1, 0, 0);
      check("flush_alloc_count", 32'(count), 32'h1);

      // Reset while waiting for the ack.
      do_reset();
      tick(1, 4'd2, 0, '0, '0, '0, 0, 0, 0, 0);
      tick(0, '0, 1, 4'd0, 32'h500, 32'hC0, 1, 0, 0, 0);
      tick(0, '0, 0, '0, '0, '0, 0, 0, 1, 0);
      check("pre_reset_count", 32'(count), 32'h1);
      do_reset();
      tick(0, '0, 0, '0, '0, '0, 0, 0, 0, 1);
      check("post_reset_ack_ignored", 32'(empty), 32'h1);

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit          a   = ($urandom % 3) != 0;
         bit          e   = ($urandom % 2) == 1;
         logic [3:0]  ei  = 4'($urandom % N);
         bit          c   = ($urandom % 3) == 0;
         bit          f   = ($urandom % 25) == 0;
         bit          rdy = ($urandom % 2) == 1;
         bit          ack = m_wait ? (($urandom % 2) == 1) : (($urandom % 10) == 0);
         if (m_valid[ei] && m_cm[ei]) e = 0;
         tick(a, 4'($urandom), e, ei, $urandom, $urandom, c, f, rdy, ack);
      end
      idle_tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_data_queue.md
STORE_DATA_QUEUE -- requirements
Module: store_data_queue

Interface
REQ-001 SHALL have parameter SDQ_ENTRIES, default 16 (from CORE_PKG), queue depth, power of two.
REQ-002 SHALL have parameter ROB_ENTRIES, default 16 (from CORE_PKG), width source for the ROB tag.
REQ-003 clk  in  1  single clock, rising edge; the only clock in the block.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 alloc_valid  in  1  dispatch requests a store slot.
REQ-006 alloc_rob_idx  in  $clog2(ROB_ENTRIES)  ROB tag of the store.
REQ-007 alloc_ready  out  1  slot available.
REQ-008 alloc_sdq_idx  out  $clog2(SDQ_ENTRIES)  index granted (tail, no wrap bit).
REQ-009 alloc_sdq_marker  out  $clog2(SDQ_ENTRIES)+1  tail including wrap bit, for ldq_entry_t.sdq_marker.
REQ-010 exec_valid  in  1  execute delivers address and data.
REQ-011 exec_sdq_idx  in  $clog2(SDQ_ENTRIES)  target entry.
REQ-012 exec_addr, exec_data  in  32 each  store address and store data.
REQ-013 commit_valid  in  1  ROB retires the oldest uncommitted store.
REQ-014 commit_rob_idx  in  $clog2(ROB_ENTRIES)  ROB tag of the retiring store (checked only).
REQ-015 flush  in  1  squash all uncommitted entries.
REQ-016 mem_req_valid, mem_req_addr, mem_req_data  out  1/32/32  D-cache write request.
REQ-017 mem_req_ready  in  1  D-cache accepts the request.
REQ-018 mem_ack  in  1  D-cache write complete.
REQ-019 empty, full  out  1 each; count  out  $clog2(SDQ_ENTRIES)+1.

Function
REQ-020 SHALL hold an array of sdq_entry_t with head, commit and tail pointers, each $clog2(SDQ_ENTRIES)+1 bits (wrap bit included).
REQ-021 count = tail-head (modular); full when count == SDQ_ENTRIES; empty when count == 0; alloc_ready = !full, with no same-cycle bypass from dealloc.
REQ-022 On alloc_valid&&alloc_ready: entry[tail] gets valid=1, addr_valid=0, committed=0, issued=0, rob_entry_idx=alloc_rob_idx; tail increments and wraps via the wrap bit.
REQ-023 On exec_valid with entry[exec_sdq_idx].valid: store addr and data and set addr_valid; if the entry is not valid, ignore the write.
REQ-024 On commit_valid: set entry[commit].committed and increment commit; commit_valid with commit==tail SHALL be ignored (assertion fires).
REQ-025 On flush: tail := commit pointer after this cycle's commit; clear valid on squashed entries; drop any same-cycle alloc, with alloc_ready forced low.
REQ-026 Flush SHALL NOT affect committed entries or an in-flight memory request.
REQ-027 Drain FSM states: IDLE and WAIT_ACK.
REQ-028 IDLE: mem_req_valid = entry[head].valid && committed && addr_valid, driven from registered state only.
REQ-029 IDLE: on mem_req_valid&&mem_req_ready, set issued and go to WAIT_ACK.
REQ-030 mem_req_valid with addr and data SHALL stay stable until mem_req_ready.
REQ-031 WAIT_ACK: mem_req_valid=0; on mem_ack, clear entry[head].valid, increment head, return to IDLE.
REQ-032 mem_ack outside WAIT_ACK SHALL be ignored.
REQ-033 Earliest timing: request the cycle after commit registers; peak drain rate one store per 2 cycles.
REQ-034 Alloc, exec, commit and ack in the same cycle SHALL all take effect.

Reset
REQ-035 rst_n low SHALL asynchronously clear pointers to 0, all valid bits to 0, and the FSM to IDLE.
REQ-036 Outputs under reset: empty=1, full=0, count=0, alloc_ready=1, mem_req_valid=0, data outputs 0.
REQ-037 Reset mid-request SHALL abandon the transaction; the cache side must also be reset.

Structure
REQ-038 sdq_entry_t, SDQ_ENTRIES and ROB_ENTRIES SHALL live in CORE_PKG.
REQ-039 The FSM state enum SHALL be local to the module.
REQ-040 No sub-module; a single module.

Verification
REQ-041 Reset, then alloc rob 3, exec addr 0x100/data 0xAA, commit -> mem_req_valid next cycle with 0x100/0xAA; ready then ack -> empty=1.
REQ-042 16 allocs -> full=1, alloc_ready=0; drain one -> alloc_ready=1, alloc_sdq_marker=5'b10000 (wrap).
REQ-043 Alloc 4, commit 2, flush -> count=2, tail=commit; both committed stores drain in order.
REQ-044 Hold mem_req_ready low 5 cycles -> request stable; mem_ack before handshake is ignored.
REQ-045 Flush and alloc in the same cycle -> alloc dropped, count unchanged except for the squash.
REQ-046 rst_n low during WAIT_ACK -> FSM to IDLE immediately, all outputs at reset values.
